// File: rtl/am_demodulator_pkg.sv
// Shared types and helpers for the AM demodulator: carrier-monitor states,
// weak-window count limit and a generic signed saturator.
package am_demodulator_pkg;

    localparam int LOST_COUNT = 3;

    typedef enum logic {
        LOCKED = 1'b0,
        LOST   = 1'b1
    } carrier_state_t;

    // Clamp a signed value into the range of a 'width'-bit two's-complement number.
    function automatic logic signed [31:0] sat_signed(input logic signed [31:0] val,
                                                      input int width);
        logic signed [31:0] lim_hi;
        logic signed [31:0] lim_lo;
        lim_hi = (32'sd1 <<< (width - 1)) - 32'sd1;
        lim_lo = -(32'sd1 <<< (width - 1));
        if (val > lim_hi) begin
            return lim_hi;
        end
        if (val < lim_lo) begin
            return lim_lo;
        end
        return val;
    endfunction

endpackage

// File: rtl/am_demodulator_integrate_dump.sv
// Full-wave rectifier followed by a boxcar integrate-and-dump over 2^WIN_LOG2
// accepted samples; emits the window mean with a one-cycle strobe.
module am_integrate_dump #(
    parameter int INPUT_WIDTH = 12,
    parameter int WIN_LOG2    = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_en,
    input  logic signed [INPUT_WIDTH-1:0] i_sample,
    output logic        [INPUT_WIDTH-1:0] o_env,
    output logic                          o_env_stb
);

    localparam int MAG_W = INPUT_WIDTH - 1;
    localparam int ACC_W = MAG_W + WIN_LOG2;

    logic signed [INPUT_WIDTH-1:0] w_neg;
    logic        [MAG_W-1:0]       w_abs;
    logic        [ACC_W-1:0]       w_sum;

    logic        [MAG_W-1:0]       r_abs;
    logic                          r_v1;
    logic        [ACC_W-1:0]       r_acc;
    logic        [WIN_LOG2-1:0]    r_cnt;
    logic        [INPUT_WIDTH-1:0] r_env;
    logic                          r_env_stb;

    always_comb begin
        w_neg = -i_sample;
        if (!i_sample[INPUT_WIDTH-1]) begin
            w_abs = i_sample[MAG_W-1:0];
        end else if (w_neg[INPUT_WIDTH-1]) begin
            // Only the most negative code negates to itself; clamp it to full scale.
            w_abs = '1;
        end else begin
            w_abs = w_neg[MAG_W-1:0];
        end
    end

    assign w_sum = r_acc + ACC_W'(r_abs);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_abs     <= '0;
            r_v1      <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_env     <= '0;
            r_env_stb <= 1'b0;
        end else begin
            r_v1      <= i_en;
            r_env_stb <= 1'b0;
            if (i_en) begin
                r_abs <= w_abs;
            end
            if (r_v1) begin
                if (r_cnt == '1) begin
                    r_env     <= {1'b0, w_sum[ACC_W-1:WIN_LOG2]};
                    r_acc     <= '0;
                    r_cnt     <= '0;
                    r_env_stb <= 1'b1;
                end else begin
                    r_acc <= w_sum;
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

    assign o_env     = r_env;
    assign o_env_stb = r_env_stb;

endmodule

// File: rtl/am_demodulator.sv
// AM envelope demodulator: integrate-and-dump envelope, first-order DC removal,
// gain with saturation, and a carrier-loss monitor.
//
// state  | meaning
// LOCKED | fewer than LOST_COUNT+1 consecutive weak windows; wave_out live
// LOST   | carrier absent; wave_out forced to 0, envelope/DC keep tracking
module am_demodulator
    import am_demodulator_pkg::*;
#(
    parameter int INPUT_WIDTH  = 12,
    parameter int OUTPUT_WIDTH = 12,
    parameter int WIN_LOG2     = 8,
    parameter int DC_SHIFT     = 10,
    parameter int GAIN_SHIFT   = 1,
    parameter int LOST_THRESH  = 64
) (
    input  logic                           clk_in,
    input  logic                           RST,
    input  logic                           in_en,
    input  logic signed [INPUT_WIDTH-1:0]  AM_wave,
    output logic signed [OUTPUT_WIDTH-1:0] wave_out,
    output logic                           wave_valid,
    output logic        [INPUT_WIDTH-1:0]  envelope,
    output logic                           carrier_lost
);

    localparam int MAG_W = INPUT_WIDTH - 1;
    localparam int DC_W  = MAG_W + DC_SHIFT;

    logic        [INPUT_WIDTH-1:0]  w_env;
    logic                           w_env_stb;
    logic        [MAG_W-1:0]        w_dc_hi;
    logic signed [INPUT_WIDTH:0]    w_ac;
    logic signed [31:0]             w_ac32;
    logic signed [OUTPUT_WIDTH-1:0] w_wave;
    logic        [DC_W-1:0]         w_dc_next;
    logic                           w_weak_win;
    logic                           w_goes_lost;

    logic        [DC_W-1:0]         r_dc_acc;
    logic                           r_seeded;
    logic        [1:0]              r_weak;
    carrier_state_t                 r_state;
    logic signed [OUTPUT_WIDTH-1:0] r_wave_out;
    logic                           r_wave_valid;
    logic        [INPUT_WIDTH-1:0]  r_envelope;
    logic                           r_carrier_lost;

    am_integrate_dump #(
        .INPUT_WIDTH (INPUT_WIDTH),
        .WIN_LOG2    (WIN_LOG2)
    ) u_integrate_dump (
        .i_clk     (clk_in),
        .i_rst     (RST),
        .i_en      (in_en),
        .i_sample  (AM_wave),
        .o_env     (w_env),
        .o_env_stb (w_env_stb)
    );

    assign w_dc_hi   = r_dc_acc[DC_W-1:DC_SHIFT];
    assign w_ac      = r_seeded ? ($signed({1'b0, w_env}) - $signed({2'b00, w_dc_hi}))
                                : '0;
    assign w_ac32    = $signed({{(31 - INPUT_WIDTH){w_ac[INPUT_WIDTH]}}, w_ac});
    assign w_wave    = OUTPUT_WIDTH'(sat_signed(w_ac32 <<< GAIN_SHIFT, OUTPUT_WIDTH));
    assign w_dc_next = r_dc_acc + DC_W'(w_env) - DC_W'(w_dc_hi);

    // The weak counter is pinned at LOST_COUNT while LOST, so this also holds LOST.
    assign w_weak_win  = (w_env < INPUT_WIDTH'(LOST_THRESH));
    assign w_goes_lost = w_weak_win && (r_weak == 2'(LOST_COUNT));

    always_ff @(posedge clk_in) begin
        if (RST) begin
            r_dc_acc       <= '0;
            r_seeded       <= 1'b0;
            r_weak         <= '0;
            r_state        <= LOCKED;
            r_wave_out     <= '0;
            r_wave_valid   <= 1'b0;
            r_envelope     <= '0;
            r_carrier_lost <= 1'b0;
        end else begin
            r_wave_valid <= 1'b0;
            if (w_env_stb) begin
                r_wave_valid <= 1'b1;
                r_envelope   <= w_env;
                r_wave_out   <= w_goes_lost ? '0 : w_wave;
                r_seeded     <= 1'b1;
                r_dc_acc     <= r_seeded ? w_dc_next : {w_env[MAG_W-1:0], {DC_SHIFT{1'b0}}};
                case (r_state)
                    LOCKED: begin
                        if (w_goes_lost) begin
                            r_state        <= LOST;
                            r_carrier_lost <= 1'b1;
                        end else if (w_weak_win) begin
                            r_weak <= r_weak + 2'd1;
                        end else begin
                            r_weak <= '0;
                        end
                    end
                    LOST: begin
                        if (!w_weak_win) begin
                            r_state        <= LOCKED;
                            r_carrier_lost <= 1'b0;
                            r_weak         <= '0;
                        end
                    end
                endcase
            end
        end
    end

    assign wave_out     = r_wave_out;
    assign wave_valid   = r_wave_valid;
    assign envelope     = r_envelope;
    assign carrier_lost = r_carrier_lost;

endmodule

// File: doc/am_demodulator.md
Name: am_demodulator

Overview:
Receive-side counterpart of the AM modulator. Takes signed AM samples, envelope-detects them, removes the carrier DC term and emits the recovered baseband wave in the same signed format the modulator accepts on wave_in. Detection is full-wave rectification, a boxcar-integrate-and-dump over 2^WIN_LOG2 samples, a first-order DC tracker and gain/saturation. The block sits after the ADC / channel path and feeds the audio output chain. It also flags carrier loss.

Parameters:
INPUT_WIDTH, 12, width of the signed AM sample input
OUTPUT_WIDTH, 12, width of the signed recovered wave
WIN_LOG2, 8, log2 of the samples per integrate-and-dump window (window = 256)
DC_SHIFT, 10, DC tracker coefficient = 2^-DC_SHIFT
GAIN_SHIFT, 1, left shift applied to the AC term before saturation
LOST_THRESH, 64, envelope below this value counts as a weak window

Ports:
clk_in  input  1  system clock
RST  input  1  reset, synchronous to clk_in, active-high
in_en  input  1  sample enable; AM_wave is consumed only when 1
AM_wave  input  INPUT_WIDTH  signed two's-complement AM sample
wave_out  output  OUTPUT_WIDTH  signed recovered baseband, held between updates
wave_valid  output  1  one-cycle strobe when wave_out/envelope update
envelope  output  INPUT_WIDTH  unsigned window-mean of |AM_wave| (MSB always 0)
carrier_lost  output  1  level; 1 after 4 consecutive weak windows

Behaviour:
- Reset is synchronous and active-high. On RST, all of the following are cleared: wave_out, envelope, wave_valid, carrier_lost, accumulator, sample counter, DC state, seeded flag and weak counter. RST mid-window discards the partial window; the next accepted sample starts a new window.
- S1, registered: abs_r = |AM_wave| when in_en=1. The most negative input, -2^(INPUT_WIDTH-1), saturates to 2^(INPUT_WIDTH-1)-1. v1 <= in_en.
- S2, integrate-and-dump, active only when v1=1:
  - Accumulator width is INPUT_WIDTH-1+WIN_LOG2, so it cannot overflow. Counter cnt runs 0..2^WIN_LOG2-1.
  - When cnt is at its maximum: env_r <= (acc+abs_r)>>WIN_LOG2 (truncating), acc <= 0, cnt <= 0, env_stb <= 1.
  - Otherwise: acc += abs_r, cnt++, env_stb <= 0.
  - in_en gaps simply pause the window; there is no timeout.
- S3, executes on env_stb:
  - The DC state dc_acc is unsigned, INPUT_WIDTH-1+DC_SHIFT bits. dc_hi = dc_acc>>DC_SHIFT.
  - Seed (first window after reset, seeded=0): dc_acc <= env_r<<DC_SHIFT, ac = 0, seeded <= 1.
  - Otherwise: ac = env_r - dc_hi, using the pre-update dc_hi and signed INPUT_WIDTH+1 bits. Then dc_acc <= dc_acc + env_r - dc_hi.
  - wave_out <= sat_OUTPUT_WIDTH(ac<<<GAIN_SHIFT). Saturation clamps symmetrically to [-(2^(OUTPUT_WIDTH-1)), 2^(OUTPUT_WIDTH-1)-1].
  - envelope <= env_r; wave_valid <= 1 for exactly one cycle.
- Carrier monitor, a 2-state FSM LOCKED/LOST with a weak counter that saturates at 3, updated on env_stb:
  - A window with env_r < LOST_THRESH increments the weak counter. When a weak window arrives with the counter already at 3, the FSM goes to LOST and carrier_lost=1, visible together with that window's wave_valid.
  - Any window with env_r >= LOST_THRESH clears the counter and returns the FSM to LOCKED in the same update.
  - While LOST (including the update that enters LOST): wave_out is forced to 0, envelope and the DC tracker still update, and wave_valid still pulses.
- Latency: the last sample of a window is accepted with in_en=1 at cycle t. wave_valid/wave_out/envelope/carrier_lost update at t+3 (S1 at t+1, S2 at t+2, S3 at t+3). At most one wave_valid per 2^WIN_LOG2 accepted samples.

Decomposition:
- Shared package: sat_signed function, LOST_COUNT=3 constant, FSM state enum {LOCKED, LOST}.
- One sub-module: am_integrate_dump. It contains S1 and S2: rectify, accumulator, counter, env_r/env_stb outputs.
- The top keeps the DC tracker, gain/saturation and carrier FSM.

Test Plan:
All scenarios use WIN_LOG2=2, DC_SHIFT=4, GAIN_SHIFT=1, LOST_THRESH=16.
1. Reset, then 4 samples of +1000 with in_en=1 -> wave_valid pulses 3 cycles after the 4th sample; envelope=1000, wave_out=0 (seed), carrier_lost=0.
2. After scenario 1, 4 samples alternating +1200/-1200 -> envelope=1200, wave_out=400. Internal dc_hi becomes 1012; the next window of 1012 gives wave_out=0.
3. Seed with 4x100, then 4x -2048 -> envelope=2047 (abs saturation), ac=1947, wave_out saturates to +2047.
4. Seed with 4x500, then 20 samples of 0 -> windows 2-5 are weak. carrier_lost=1 at the 5th window's wave_valid (4th consecutive weak window) with wave_out=0. The next window of 4x500 -> carrier_lost=0.
5. in_en toggled 1/0 every cycle over 8 samples of +300 -> exactly 2 wave_valid pulses, envelope=300, no pulse during gaps.
6. Assert RST after 2 of 4 samples (+900), release, then 4x +200 -> first pulse reports envelope=200, wave_out=0 (re-seed). The partial window is never output.
